// File: rtl/sfp_pkg.sv
// Shared sizing and FSM encoding for the softmax-style
// row normalization sequencer.
package sfp_pkg;

    localparam int COL     = 8;
    localparam int BW      = 8;
    localparam int BW_PSUM = 2 * BW + 4;
    localparam int ROWS    = 16;
    localparam int AW      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_WAIT_PEER,
        S_DIV,
        S_FLUSH,
        S_DONE
    } sfp_state_t;

endpackage

// File: rtl/sfp_row_cnt.sv
// Row address counter: clears on load, steps on enable,
// holds at the terminal row of the current pass.
module sfp_row_cnt
    import sfp_pkg::*;
#(
    parameter int aw = AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [aw:0]   limit,
    output logic [aw-1:0] cnt,
    output logic          last
);

    assign last = ({1'b0, cnt} == (limit - 1'b1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sfp_seq.sv
// Two-phase normalization sequencer: accumulate row sums,
// wait for the peer core, then divide and write back.
module sfp_seq
    import sfp_pkg::*;
#(
    parameter int col     = COL,
    parameter int bw      = BW,
    parameter int bw_psum = 2 * bw + 4,
    parameter int rows    = ROWS,
    parameter int aw      = AW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [aw:0]            nrows,
    input  logic                   peer_ready,
    output logic                   psum_cen,
    output logic [aw-1:0]          psum_addr,
    input  logic [col*bw_psum-1:0] psum_q,
    output logic [col*bw_psum-1:0] sfp_in,
    output logic                   acc,
    output logic                   div,
    output logic                   ext_rd,
    input  logic [col*bw_psum-1:0] sfp_out,
    output logic                   out_wen,
    output logic [aw-1:0]          out_addr,
    output logic [col*bw_psum-1:0] out_d,
    output logic                   busy,
    output logic                   done
);

    localparam logic [aw:0] ROWS_W = (aw + 1)'(rows);

    sfp_state_t    state;
    logic [aw:0]   n_lat;
    logic [aw:0]   n_clamp;
    logic [aw-1:0] vld_row;
    logic [aw-1:0] cnt;
    logic          last;
    logic          cnt_load;
    logic          cnt_en;

    assign n_clamp = (nrows > ROWS_W) ? ROWS_W : nrows;

    assign cnt_load = ((state == S_IDLE) && start && (n_clamp != '0))
                    || ((state == S_WAIT_PEER) && peer_ready);
    assign cnt_en   = ((state == S_ACC) || (state == S_DIV)) && !psum_cen;

    assign psum_addr = cnt;

    // Read data is only forwarded while sfp_row is consuming it.
    assign sfp_in = (acc || div) ? psum_q : '0;

    sfp_row_cnt #(
        .aw (aw)
    ) u_row_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .en    (cnt_en),
        .limit (n_lat),
        .cnt   (cnt),
        .last  (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            n_lat    <= '0;
            vld_row  <= '0;
            psum_cen <= 1'b1;
            acc      <= 1'b0;
            div      <= 1'b0;
            ext_rd   <= 1'b0;
            out_wen  <= 1'b1;
            out_addr <= '0;
            out_d    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (n_clamp == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            n_lat    <= n_clamp;
                            psum_cen <= 1'b0;
                            state    <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    acc     <= !psum_cen;
                    vld_row <= psum_addr;
                    if (!psum_cen && last) begin
                        psum_cen <= 1'b1;
                    end
                    if (psum_cen && acc) begin
                        state <= S_WAIT_PEER;
                    end
                end
                S_WAIT_PEER: begin
                    if (peer_ready) begin
                        psum_cen <= 1'b0;
                        state    <= S_DIV;
                    end
                end
                S_DIV: begin
                    div     <= !psum_cen;
                    ext_rd  <= !psum_cen;
                    vld_row <= psum_addr;
                    out_wen <= !div;
                    if (div) begin
                        out_addr <= vld_row;
                        out_d    <= sfp_out;
                    end
                    if (!psum_cen && last) begin
                        psum_cen <= 1'b1;
                    end
                    if (psum_cen && div) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    out_wen <= 1'b1;
                    done    <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sfp_seq.md
SFP_SEQ -- requirements
Module: sfp_seq

Interface
REQ-001 Parameters SHALL be: col 8, column count; bw 8, activation width; bw_psum 2*bw+4, psum width; rows 16, max rows per pass (matches the sfp_row FIFO depth); aw 4, address width.
REQ-002 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port start, input, 1: single-cycle request to begin a normalization pass.
REQ-005 Port nrows, input, aw+1: row count for the pass (0..rows); sampled on an accepted start.
REQ-006 Port peer_ready, input, 1: peer core's row sums are in its ext FIFO; arrives already synchronized to clk.
REQ-007 Port psum_cen, output, 1: active-low psum memory read enable.
REQ-008 Port psum_addr, output, aw: psum memory read address.
REQ-009 Port psum_q, input, col*bw_psum: psum read data, valid 1 cycle after psum_cen low.
REQ-010 Port sfp_in, output, col*bw_psum: row data forwarded to sfp_row.
REQ-011 Ports acc, div, ext_rd, output, 1 each: sfp_row acc, sfp_row div, peer ext-FIFO pop.
REQ-012 Port sfp_out, input, col*bw_psum: normalized row returned from sfp_row.
REQ-013 Ports out_wen (active-low, 1), out_addr (aw), out_d (col*bw_psum), output: result memory write.
REQ-014 Ports busy (1) and done (1, one-cycle pulse), output.

Function
REQ-015 FSM states SHALL be IDLE, ACC, WAIT_PEER, DIV, FLUSH, DONE.
REQ-016 In IDLE, start with nrows>0 SHALL go to ACC and latch nrows; start with nrows==0 SHALL go to DONE without touching the memory; start while busy SHALL be ignored.
REQ-017 In ACC, row counter r SHALL issue reads at addresses 0..nrows-1 on consecutive cycles; acc SHALL be high exactly in each cycle where psum_q is valid, with sfp_in = psum_q combinationally.
REQ-018 After the last acc cycle, the FSM SHALL enter WAIT_PEER; if peer_ready is already high it SHALL leave on the next edge (no extra wait cycle).
REQ-019 In DIV, rows 0..nrows-1 SHALL be re-read; div and ext_rd SHALL both be high in each data-valid cycle, one row per cycle.
REQ-020 The sfp_out result SHALL be written 1 cycle after each div cycle: out_wen low, out_addr = row index, out_d = sfp_out.
REQ-021 FLUSH SHALL last exactly 1 cycle to retire the final write; DONE SHALL pulse done for 1 cycle, then return to IDLE.
REQ-022 busy SHALL be high in every state except IDLE.
REQ-023 acc and div SHALL never be high in the same cycle.
REQ-024 The number of acc pulses, div pulses, ext_rd pulses and writes per pass SHALL each equal nrows.
REQ-025 nrows > rows SHALL be clamped to rows.
REQ-026 peer_ready dropping during DIV SHALL be ignored; it is checked only in WAIT_PEER.
REQ-027 Pass latency SHALL be nrows+2 cycles per phase plus wait time: for nrows=N with peer_ready high, done pulses 2N+5 cycles after start.

Reset
REQ-028 While reset is low: state IDLE, counters 0, psum_cen=1, out_wen=1, acc=div=ext_rd=0, busy=0, done=0, addresses 0, sfp_in/out_d 0.
REQ-029 Reset asserted mid-pass SHALL abort immediately with no further reads or writes; the next pass SHALL require a new start.

Structure
REQ-030 col, bw, bw_psum, rows and the FSM state encoding SHALL live in the shared sfp package.
REQ-031 The row address counter SHALL be a sub-module named sfp_row_cnt (load, enable, terminal flag); everything else is flat.

Verification
REQ-032 nrows=4, peer_ready=1, rows hold {+3,-5,...}: exactly 4 acc pulses at cycles 2..5, 4 div/ext_rd pulses, writes to addresses 0..3, done at cycle 13.
REQ-033 nrows=0: done 1 cycle after start; psum_cen and out_wen stay high throughout.
REQ-034 peer_ready held low 10 cycles after ACC ends: FSM stays in WAIT_PEER with zero div pulses, then completes normally.
REQ-035 start re-pulsed during DIV: ignored; write count stays nrows.
REQ-036 reset pulled low during ACC row 2: all outputs return to reset values asynchronously; a new start with nrows=16 completes with 16 writes (rows 0..15).
REQ-037 nrows=20: clamped, so exactly 16 acc and 16 div pulses.
